pb_input_conditioner: RTL and testbench
=======================================

Name: pb_input_conditioner

Overview:
- Input-side counterpart to the clock's display path. Conditions the raw pushbutton bus IO_PB before the time-setup and mode logic reads it.
- Per button: synchronizes the input, debounces it, and emits single-cycle press, release and long-press pulses, plus optional auto-repeat pulses.
- Also flags the two-button "re-enter setup" chord.
- Sits between the board pins and the clock/setup state machines. Downstream logic consumes pulses only and never raw button levels.

Parameters:
- NUM_PB, 4: number of pushbuttons conditioned.
- DEBOUNCE_CYCLES, 500000: cycles a synchronized level must stay stable before it is accepted (10 ms at 50 MHz).
- LONG_PRESS_CYCLES, 50000000: held cycles, after acceptance, before the long-press pulse (1 s).
- REPEAT_CYCLES, 12500000: auto-repeat period after a long press (0.25 s).
- CHORD_A, 0: first button index of the chord.
- CHORD_B, 3: second button index of the chord.

Ports:
- M_CLOCK  in  1  system clock, 50 MHz.
- M_RESET_N  in  1  asynchronous, active-low reset.
- IO_PB  in  NUM_PB  raw pushbuttons, active-high, asynchronous to M_CLOCK.
- pb_level  out  NUM_PB  debounced level, 1 = pressed.
- pb_press  out  NUM_PB  1-cycle pulse on accepted press.
- pb_release  out  NUM_PB  1-cycle pulse on accepted release.
- pb_long  out  NUM_PB  1-cycle pulse when held LONG_PRESS_CYCLES.
- pb_repeat  out  NUM_PB  1-cycle auto-repeat pulse (tied 0 when the feature is excluded).
- chord  out  1  1-cycle pulse when CHORD_A and CHORD_B become held together.

Interface: one clock, M_CLOCK. Reset M_RESET_N is asynchronous and active-low. All state is cleared on its assertion and starts updating on the first M_CLOCK rising edge after deassertion.

Behaviour:
- Reset: every output is 0. Synchronizers, stable levels, and debounce/hold/repeat counters are all 0.
- Reset mid-press clears everything. A button still held after reset is re-accepted as a fresh press, with full debounce.
- Synchronizer: 2 flops per button. sync[i] is IO_PB[i] delayed by 2 cycles.
- Debounce, per button:
  - If sync != pb_level, db_cnt increments. If sync == pb_level, db_cnt clears to 0.
  - When db_cnt == DEBOUNCE_CYCLES-1 and sync still differs, pb_level toggles on the next edge and db_cnt clears.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count and is never seen.
- Latency: IO_PB change stable at edge k gives the pb_level change visible after edge k+2+DEBOUNCE_CYCLES.
- Edge pulses:
  - pb_press[i] is registered and high for exactly the cycle in which pb_level[i] first reads 1.
  - pb_release[i] likewise for the first cycle pb_level[i] reads 0.
- Hold counter, per button:
  - hold_cnt clears whenever pb_level == 0. While pb_level == 1 it increments and saturates at LONG_PRESS_CYCLES.
  - pb_long pulses once, in the cycle hold_cnt reaches LONG_PRESS_CYCLES-1.
  - A release before that point gives no long pulse. A press held forever gives exactly one long pulse.
- Chord:
  - chord pulses on the rising edge of (pb_level[CHORD_A] & pb_level[CHORD_B]).
  - Order of arrival is irrelevant. Simultaneous acceptance of both is valid.
  - While the chord is held, pb_long and pb_repeat for CHORD_A and CHORD_B are suppressed. Suppression lasts until both buttons read released.
  - pb_press and pb_release for the chord buttons are still emitted.
- Independence: buttons are fully independent apart from chord suppression. Any combination of simultaneous pulses on different bits is legal.
- Widths: counters are sized with $clog2 of their limit plus 1. No wrap is possible; the hold counter saturates.

Optional Feature:
- Macro: PB_AUTOREPEAT_EN.
- Defined:
  - Once pb_long has fired for button i and it stays pressed, rep_cnt counts and pb_repeat[i] pulses every REPEAT_CYCLES cycles.
  - The first repeat pulse comes REPEAT_CYCLES cycles after the pb_long pulse.
  - Release clears rep_cnt immediately. Chord suppression applies.
- Undefined: no repeat counter is instantiated and pb_repeat is constant 0.

Decomposition:
- Package pb_cond_pkg:
  - default cycle constants derived from a 50 MHz clock;
  - function for counter width from a limit.
- Sub-module pb_debounce_channel, instantiated NUM_PB times via generate:
  - contains the synchronizer, debounce, edge pulses, hold counter and optional repeat logic;
  - takes a suppress input for chord gating.
- Top level holds only the chord detector and the suppression flag.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=5.
- Scenario 1, clean press: IO_PB[1] rises and holds 10 cycles -> pb_level[1]=1 at edge +6; pb_press[1] high exactly 1 cycle; pb_long, pb_release stay 0.
- Scenario 2, bounce: IO_PB[2] toggles 1/0 every 2 cycles for 12 cycles, then stays 1 -> no pulse during bounce; a single pb_press[2] 6 cycles after the final rise.
- Scenario 3, long press and repeat: hold IO_PB[0] for 40 cycles after acceptance.
  - With PB_AUTOREPEAT_EN: pb_long at hold 19, pb_repeat at hold 24, 29, 34, 39.
  - Without the macro: pb_long once, pb_repeat never.
- Scenario 4, chord: press PB0, then PB3 three cycles later, hold 60 cycles.
  - Expect 2 pb_press pulses and 1 chord pulse, aligned with pb_level[3] rising.
  - No pb_long or pb_repeat on bits 0 and 3.
  - On release, 2 pb_release pulses.
- Scenario 5, reset mid-hold: assert M_RESET_N=0 at hold 10 while PB1 is held -> all outputs 0 asynchronously. After deassertion, pb_press[1] re-fires at +6 cycles.
- Scenario 6, short glitch: a 3-cycle pulse on IO_PB[3] -> pb_level, pb_press and pb_release all stay 0.

Source files
------------

// File: rtl/pb_cond_pkg.sv
// Shared constants and helpers for the pushbutton input conditioner.
// Cycle defaults assume a 50 MHz M_CLOCK.
package pb_cond_pkg;

    localparam int unsigned CLK_HZ                = 50_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES   = CLK_HZ / 100;  // 10 ms
    localparam int unsigned DEF_LONG_PRESS_CYCLES = CLK_HZ;        // 1 s
    localparam int unsigned DEF_REPEAT_CYCLES     = CLK_HZ / 4;    // 0.25 s

    // Counter width able to hold the value 'limit' without wrapping.
    function automatic int cntWidth(input int unsigned limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/pb_debounce_channel.sv
// One pushbutton channel: 2-flop synchronizer, debounce, press/release
// pulses, long-press detection and optional auto-repeat.
// Auto-repeat is built only when PB_AUTOREPEAT_EN is defined; otherwise
// pbRepeat is tied low and no repeat counter exists.
module pb_debounce_channel
    import pb_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
    input  logic M_CLOCK,
    input  logic M_RESET_N,
    input  logic pbRaw,
    input  logic suppress,
    output logic pbLevel,
    output logic pbPress,
    output logic pbRelease,
    output logic pbLong,
    output logic pbRepeat
);

    localparam int DB_W   = cntWidth(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cntWidth(LONG_PRESS_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

    logic              syncMeta;
    logic              syncQ;
    logic [DB_W-1:0]   dbCnt;
    logic [HOLD_W-1:0] holdCnt;
    logic              differs;
    logic              accept;
    logic              levelNext;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            syncMeta <= 1'b0;
            syncQ    <= 1'b0;
        end else begin
            syncMeta <= pbRaw;
            syncQ    <= syncMeta;
        end
    end

    // Accept the synchronized level once it has disagreed for DEBOUNCE_CYCLES.
    always_comb begin
        differs   = syncQ ^ pbLevel;
        accept    = differs && (dbCnt == DB_LAST);
        levelNext = pbLevel ^ accept;
    end

    // Debounce counter, accepted level and the registered edge pulses.
    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            dbCnt     <= '0;
            pbLevel   <= 1'b0;
            pbPress   <= 1'b0;
            pbRelease <= 1'b0;
        end else begin
            if (!differs || accept) begin
                dbCnt <= '0;
            end else begin
                dbCnt <= dbCnt + 1'b1;
            end
            pbLevel   <= levelNext;
            pbPress   <= accept & ~pbLevel;
            pbRelease <= accept &  pbLevel;
        end
    end

    // Cycles held since acceptance (0 in the acceptance cycle), saturating.
    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            holdCnt <= '0;
        end else if (!levelNext || !pbLevel) begin
            holdCnt <= '0;
        end else if (holdCnt != HOLD_MAX) begin
            holdCnt <= holdCnt + 1'b1;
        end
    end

    assign pbLong = pbLevel & (holdCnt == HOLD_LONG) & ~suppress;

`ifdef PB_AUTOREPEAT_EN
    localparam int REP_W = cntWidth(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES);

    logic [REP_W-1:0] repCnt;

    // Repeat phase runs 1..REPEAT_CYCLES from the long-press cycle onward.
    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            repCnt <= '0;
        end else if (!levelNext || !pbLevel || (holdCnt < HOLD_LONG)) begin
            repCnt <= '0;
        end else if (repCnt == REP_LAST) begin
            repCnt <= REP_W'(1);
        end else begin
            repCnt <= repCnt + 1'b1;
        end
    end

    assign pbRepeat = pbLevel & (repCnt == REP_LAST) & ~suppress;
`else
    // REPEAT_CYCLES is still referenced so both builds share one interface.
    assign pbRepeat = (REPEAT_CYCLES == 0) & 1'b0;
`endif

endmodule

// File: rtl/pb_input_conditioner.sv
// Pushbutton input conditioner: one debounce channel per button plus the
// two-button chord detector that gates long/repeat pulses of its buttons.
// Optional auto-repeat in the channels is enabled by PB_AUTOREPEAT_EN.
module pb_input_conditioner
    import pb_cond_pkg::*;
#(
    parameter int unsigned NUM_PB            = 4,
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
    parameter int unsigned CHORD_A           = 0,
    parameter int unsigned CHORD_B           = 3
) (
    input  logic              M_CLOCK,
    input  logic              M_RESET_N,
    input  logic [NUM_PB-1:0] IO_PB,
    output logic [NUM_PB-1:0] pb_level,
    output logic [NUM_PB-1:0] pb_press,
    output logic [NUM_PB-1:0] pb_release,
    output logic [NUM_PB-1:0] pb_long,
    output logic [NUM_PB-1:0] pb_repeat,
    output logic              chord
);

    logic chordNow;
    logic chordPrev;
    logic suppFlag;
    logic suppressChord;

    // Chord edge and suppression: held from chord until both buttons are up.
    always_comb begin
        chordNow      = pb_level[CHORD_A] & pb_level[CHORD_B];
        chord         = chordNow & ~chordPrev;
        suppressChord = chordNow | (suppFlag & (pb_level[CHORD_A] | pb_level[CHORD_B]));
    end

    // Chord history and the sticky suppression flag.
    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            chordPrev <= 1'b0;
            suppFlag  <= 1'b0;
        end else begin
            chordPrev <= chordNow;
            if (chordNow) begin
                suppFlag <= 1'b1;
            end else if (!pb_level[CHORD_A] && !pb_level[CHORD_B]) begin
                suppFlag <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_PB; i++) begin : gChan
        pb_debounce_channel #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
            .REPEAT_CYCLES     (REPEAT_CYCLES)
        ) uChan (
            .M_CLOCK   (M_CLOCK),
            .M_RESET_N (M_RESET_N),
            .pbRaw     (IO_PB[i]),
            .suppress  (((i == CHORD_A) || (i == CHORD_B)) ? suppressChord : 1'b0),
            .pbLevel   (pb_level[i]),
            .pbPress   (pb_press[i]),
            .pbRelease (pb_release[i]),
            .pbLong    (pb_long[i]),
            .pbRepeat  (pb_repeat[i])
        );
    end

endmodule

// File: tb/tb_pb_input_conditioner.sv
// Scoreboard bench for pb_input_conditioner: a behavioural model pushes the
// expected pulses per cycle, a monitor pops them as the DUT presents pulses.
module tb_pb_input_conditioner;

    localparam int NPB  = 4;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;
    localparam int CA   = 0;
    localparam int CB   = 3;

    logic           M_CLOCK   = 1'b0;
    logic           M_RESET_N = 1'b1;
    logic [NPB-1:0] IO_PB     = '0;
    logic [NPB-1:0] pb_level, pb_press, pb_release, pb_long, pb_repeat;
    logic           chord;

    pb_input_conditioner #(
        .NUM_PB(NPB), .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG),
        .REPEAT_CYCLES(REP), .CHORD_A(CA), .CHORD_B(CB)
    ) dut (
        .M_CLOCK(M_CLOCK), .M_RESET_N(M_RESET_N), .IO_PB(IO_PB),
        .pb_level(pb_level), .pb_press(pb_press), .pb_release(pb_release),
        .pb_long(pb_long), .pb_repeat(pb_repeat), .chord(chord)
    );

    always #5 M_CLOCK = ~M_CLOCK;

    typedef struct { int unsigned cyc; int kind; int idx; } evt_t;
    evt_t expQ[$];

    int          nCompared = 0;
    int          nMism     = 0;
    int unsigned cyc       = 0;
    logic [NPB-1:0] expLevel = '0;
    string kindName [5] = '{"press", "release", "long", "repeat", "chord"};

    int          obs     [5][NPB];
    int unsigned lastCyc [5][NPB];
    int          lvlHigh [NPB];

    // ---------------- reference model ----------------
    bit          pinHist [NPB][DEB+2];   // pin samples, [0] = this edge
    bit          mLvl    [NPB];
    int unsigned held    [NPB];
    bit          nl [NPB], pr [NPB], rl [NPB], lg [NPB], rp [NPB];
    bit          bothPrev, latch, both, chE, supp;
    int          ones;

    initial begin
        forever begin
            @(posedge M_CLOCK);
            cyc++;
            if (!M_RESET_N) begin
                for (int i = 0; i < NPB; i++) begin
                    for (int k = 0; k < DEB + 2; k++) pinHist[i][k] = 1'b0;
                    mLvl[i] = 1'b0;
                    held[i] = 0;
                end
                bothPrev = 1'b0;
                latch    = 1'b0;
                expLevel = '0;
            end else begin
                for (int i = 0; i < NPB; i++) begin
                    for (int k = DEB + 1; k > 0; k--) pinHist[i][k] = pinHist[i][k-1];
                    pinHist[i][0] = IO_PB[i];
                    // level follows the pin once it read the same value on
                    // DEB consecutive samples, seen through two sync stages
                    ones = 0;
                    for (int k = 2; k <= DEB + 1; k++) ones += int'(pinHist[i][k]);
                    nl[i] = (ones == DEB) ? 1'b1 : ((ones == 0) ? 1'b0 : mLvl[i]);
                    pr[i] = nl[i] && !mLvl[i];
                    rl[i] = !nl[i] && mLvl[i];
                    held[i] = (nl[i] && mLvl[i]) ? held[i] + 1 : 0;
                end
                both     = nl[CA] && nl[CB];
                chE      = both && !bothPrev;
                bothPrev = both;
                latch    = both || (latch && (nl[CA] || nl[CB]));
                for (int i = 0; i < NPB; i++) begin
                    supp  = latch && ((i == CA) || (i == CB));
                    lg[i] = nl[i] && (held[i] == LONG - 1) && !supp;
                    rp[i] = 1'b0;
`ifdef PB_AUTOREPEAT_EN
                    rp[i] = nl[i] && (held[i] >= LONG - 1 + REP) &&
                            (((held[i] - (LONG - 1)) % REP) == 0) && !supp;
`endif
                    mLvl[i]     = nl[i];
                    expLevel[i] = nl[i];
                end
                for (int i = 0; i < NPB; i++) if (pr[i]) expQ.push_back(evt_t'{cyc, 0, i});
                for (int i = 0; i < NPB; i++) if (rl[i]) expQ.push_back(evt_t'{cyc, 1, i});
                for (int i = 0; i < NPB; i++) if (lg[i]) expQ.push_back(evt_t'{cyc, 2, i});
                for (int i = 0; i < NPB; i++) if (rp[i]) expQ.push_back(evt_t'{cyc, 3, i});
                if (chE) expQ.push_back(evt_t'{cyc, 4, 0});
            end
        end
    end

    function automatic logic sig(int k, int b);
        case (k)
            0:       return pb_press[b];
            1:       return pb_release[b];
            2:       return pb_long[b];
            3:       return pb_repeat[b];
            default: return chord;
        endcase
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge M_CLOCK);
            while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
                nCompared++;
                nMism++;
                $display("FAIL missing_%s bit%0d: got no pulse, required pulse in cycle %0d",
                         kindName[expQ[0].kind], expQ[0].idx, expQ[0].cyc);
                void'(expQ.pop_front());
            end
            for (int k = 0; k < 5; k++) begin
                for (int b = 0; b < NPB; b++) begin
                    if (k == 4 && b > 0) continue;
                    if (sig(k, b) === 1'b1) begin
                        obs[k][b]++;
                        lastCyc[k][b] = cyc;
                        nCompared++;
                        if (expQ.size() > 0 && expQ[0].cyc == cyc &&
                            expQ[0].kind == k && expQ[0].idx == b) begin
                            void'(expQ.pop_front());
                        end else begin
                            nMism++;
                            $display("FAIL unexpected_%s bit%0d: got pulse in cycle %0d, required none",
                                     kindName[k], b, cyc);
                        end
                    end
                end
            end
            for (int b = 0; b < NPB; b++) if (pb_level[b] === 1'b1) lvlHigh[b]++;
            nCompared++;
            if (pb_level !== expLevel) begin
                nMism++;
                $display("FAIL level cycle %0d: got %b, required %b", cyc, pb_level, expLevel);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check(string name, int act, int exp);
        nCompared++;
        if (act != exp) begin
            nMism++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge M_CLOCK);
        #2;
    endtask

    task automatic clearObs();
        for (int k = 0; k < 5; k++)
            for (int b = 0; b < NPB; b++) obs[k][b] = 0;
        for (int b = 0; b < NPB; b++) lvlHigh[b] = 0;
    endtask

    function automatic int allOutputs();
        return int'({pb_level, pb_press, pb_release, pb_long, pb_repeat, chord});
    endfunction

    initial begin
        clearObs();
        M_RESET_N = 1'b0;
        step(1);
        check("reset_outputs", allOutputs(), 0);
        step(2);
        M_RESET_N = 1'b1;
        step(3);

        // clean press on PB1
        clearObs();
        IO_PB[1] = 1'b1;
        step(10);
        check("s1_press", obs[0][1], 1);
        check("s1_release_while_held", obs[1][1], 0);
        check("s1_long", obs[2][1], 0);
        IO_PB[1] = 1'b0;
        step(12);
        check("s1_release", obs[1][1], 1);

        // bouncing PB2, then stable
        clearObs();
        for (int r = 0; r < 3; r++) begin
            IO_PB[2] = 1'b1; step(2);
            IO_PB[2] = 1'b0; step(2);
        end
        IO_PB[2] = 1'b1;
        step(5);
        check("s2_no_press_in_bounce", obs[0][2], 0);
        step(5);
        check("s2_press", obs[0][2], 1);
        IO_PB[2] = 1'b0;
        step(12);
        check("s2_release", obs[1][2], 1);

        // long press and repeat on PB0
        clearObs();
        IO_PB[0] = 1'b1;
        step(40);
        IO_PB[0] = 1'b0;
        step(12);
        check("s3_long", obs[2][0], 1);
`ifdef PB_AUTOREPEAT_EN
        check("s3_repeat", obs[3][0], 4);
`else
        check("s3_repeat", obs[3][0], 0);
`endif
        check("s3_release", obs[1][0], 1);

        // chord PB0 + PB3
        clearObs();
        IO_PB[0] = 1'b1;
        step(3);
        IO_PB[3] = 1'b1;
        step(60);
        IO_PB[0] = 1'b0;
        IO_PB[3] = 1'b0;
        step(12);
        check("s4_press0", obs[0][0], 1);
        check("s4_press3", obs[0][3], 1);
        check("s4_chord", obs[4][0], 1);
        check("s4_chord_align", int'(lastCyc[4][0]), int'(lastCyc[0][3]));
        check("s4_long", obs[2][0] + obs[2][3], 0);
        check("s4_repeat", obs[3][0] + obs[3][3], 0);
        check("s4_release", obs[1][0] + obs[1][3], 2);

        // reset in the middle of a hold on PB1
        clearObs();
        IO_PB[1] = 1'b1;
        step(16);
        M_RESET_N = 1'b0;
        #1;
        check("s5_async_reset", allOutputs(), 0);
        step(2);
        M_RESET_N = 1'b1;
        step(10);
        check("s5_press_again", obs[0][1], 2);
        IO_PB[1] = 1'b0;
        step(12);

        // 3-cycle glitch on PB3
        clearObs();
        IO_PB[3] = 1'b1;
        step(3);
        IO_PB[3] = 1'b0;
        step(12);
        check("s6_level", lvlHigh[3], 0);
        check("s6_press", obs[0][3], 0);
        check("s6_release", obs[1][3], 0);

        // randomized activity: fast chatter, then slow presses
        for (int n = 0; n < 800; n++) begin
            for (int b = 0; b < NPB; b++)
                if ($urandom_range(0, 11) == 0) IO_PB[b] = ~IO_PB[b];
            step(1);
        end
        for (int n = 0; n < 1200; n++) begin
            for (int b = 0; b < NPB; b++)
                if ($urandom_range(0, 49) == 0) IO_PB[b] = ~IO_PB[b];
            step(1);
        end
        IO_PB = '0;
        step(30);

        while (expQ.size() > 0) begin
            nCompared++;
            nMism++;
            $display("FAIL leftover_%s bit%0d: got no pulse, required pulse in cycle %0d",
                     kindName[expQ[0].kind], expQ[0].idx, expQ[0].cyc);
            void'(expQ.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMism);
        $finish;
    end

endmodule
